// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_BUSY_TIMEOUT = 16;
    localparam int TX_COUNT_W       = 16;
    localparam int BYTE_W           = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BUSY = 2'd1,
        ST_WAIT_DONE = 2'd2
    } arb_state_e;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int gid_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester bundle plus transmitter write/busy handshake shared by arbiter and its users.
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [BYTE_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ack;
    logic                      tx_write;
    logic [BYTE_W-1:0]         tx_data;
    logic                      tx_busy;

    modport master (
        output req_valid, req_data, tx_busy,
        input  req_ack, tx_write, tx_data
    );

    modport slave (
        input  req_valid, req_data, tx_busy,
        output req_ack, tx_write, tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_select.sv
// Combinational round-robin pick: first valid requester after last_grant, wrapping.
module rr_select
    import uart_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    localparam int GW      = gid_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [GW-1:0]      last_grant_i,
    output logic [GW-1:0]      winner_o,
    output logic               any_o
);

    logic          found;
    logic [GW-1:0] idx;
    int            pos;

    always_comb begin
        found    = 1'b0;
        winner_o = '0;
        idx      = '0;
        pos      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            pos = (int'(last_grant_i) + k) % NUM_REQ;
            idx = GW'(pos);
            if (!found && valid_i[idx]) begin
                found    = 1'b1;
                winner_o = idx;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte requesters with round-robin grants,
// a tx_busy start timeout and a completed-frame counter.
//
//   state        | meaning
//   ST_IDLE      | no frame outstanding; grant on any req_valid
//   ST_WAIT_BUSY | byte written, waiting for tx_busy to rise (timed)
//   ST_WAIT_DONE | frame on the line, waiting for tx_busy to fall
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int NUM_REQ      = DEF_NUM_REQ,
    parameter  int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT,
    localparam int GW           = gid_width(NUM_REQ),
    localparam int TW           = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1
) (
    input  logic                  clk_50M,
    input  logic                  reset_n,
    uart_tx_arbiter_if.slave      bus,
    output logic [GW-1:0]         grant_id,
    output logic                  busy,
    output logic                  timeout_err,
    output logic [TX_COUNT_W-1:0] tx_count
);

    arb_state_e            state_q, state_d;
    logic [GW-1:0]         last_grant_q, last_grant_d;
    logic [TW-1:0]         tmo_cnt_q, tmo_cnt_d;
    logic                  tx_write_q, tx_write_d;
    logic [NUM_REQ-1:0]    ack_q, ack_d;
    logic [BYTE_W-1:0]     tx_data_q, tx_data_d;
    logic [GW-1:0]         grant_q, grant_d;
    logic                  busy_q, busy_d;
    logic                  terr_q, terr_d;
    logic [TX_COUNT_W-1:0] tx_count_q, tx_count_d;

    logic [GW-1:0]         win;
    logic                  any_valid;

    rr_select #(.NUM_REQ(NUM_REQ)) u_rr (
        .valid_i      (bus.req_valid),
        .last_grant_i (last_grant_q),
        .winner_o     (win),
        .any_o        (any_valid)
    );

    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GW'(NUM_REQ - 1);
            tmo_cnt_q    <= '0;
            tx_write_q   <= 1'b0;
            ack_q        <= '0;
            tx_data_q    <= '0;
            grant_q      <= '0;
            busy_q       <= 1'b0;
            terr_q       <= 1'b0;
            tx_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            tmo_cnt_q    <= tmo_cnt_d;
            tx_write_q   <= tx_write_d;
            ack_q        <= ack_d;
            tx_data_q    <= tx_data_d;
            grant_q      <= grant_d;
            busy_q       <= busy_d;
            terr_q       <= terr_d;
            tx_count_q   <= tx_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        tmo_cnt_d    = tmo_cnt_q;
        tx_write_d   = 1'b0;
        ack_d        = '0;
        tx_data_d    = tx_data_q;
        grant_d      = grant_q;
        terr_d       = 1'b0;
        tx_count_d   = tx_count_q;

        case (state_q)
            ST_IDLE: begin
                // A stray tx_busy here is deliberately not looked at.
                tmo_cnt_d = '0;
                if (any_valid) begin
                    state_d      = ST_WAIT_BUSY;
                    tx_write_d   = 1'b1;
                    ack_d[win]   = 1'b1;
                    tx_data_d    = bus.req_data[{win, 3'b000} +: BYTE_W];
                    grant_d      = win;
                    last_grant_d = win;
                end
            end
            ST_WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_d   = ST_WAIT_DONE;
                    tmo_cnt_d = '0;
                end else if (tmo_cnt_q == TW'(BUSY_TIMEOUT - 1)) begin
                    state_d   = ST_IDLE;
                    terr_d    = 1'b1;
                    tmo_cnt_d = '0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_d    = ST_IDLE;
                    tx_count_d = tx_count_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign bus.tx_write = tx_write_q;
    assign bus.req_ack  = ack_q;
    assign bus.tx_data  = tx_data_q;
    assign grant_id     = grant_q;
    assign busy         = busy_q;
    assign timeout_err  = terr_q;
    assign tx_count     = tx_count_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: grant-order vectors, timeout/reset/wrap
// sequences and a randomized run against a queue-based requester model.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int NR = 4;
    localparam int BT = 16;

    logic        clk_50M = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  grant_id;
    logic        busy;
    logic        timeout_err;
    logic [15:0] tx_count;
    logic        model_busy;
    logic        stray_busy;

    always #10 clk_50M = ~clk_50M;

    uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();
    assign bus.tx_busy = model_busy | stray_busy;

    uart_tx_arbiter #(.NUM_REQ(NR), .BUSY_TIMEOUT(BT)) dut (
        .clk_50M     (clk_50M),
        .reset_n     (reset_n),
        .bus         (bus),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err),
        .tx_count    (tx_count)
    );

    int n_cmp;
    int n_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Transmitter stand-in: tx_busy rises tx_delay cycles after a write, stays up tx_len cycles.
    int tx_delay;
    int tx_len;
    bit tx_never;
    int dly;
    int len;
    int len_cfg;

    initial begin
        model_busy = 1'b0;
        dly = 0;
        len = 0;
        len_cfg = 0;
        forever begin
            @(negedge clk_50M);
            if (!reset_n) begin
                model_busy = 1'b0;
                dly = 0;
                len = 0;
            end else begin
                if (len > 0) begin
                    len--;
                    if (len == 0) model_busy = 1'b0;
                end
                if (dly > 0) begin
                    dly--;
                    if (dly == 0) begin
                        model_busy = 1'b1;
                        len = len_cfg;
                    end
                end
                if (bus.tx_write && !tx_never) begin
                    dly = tx_delay;
                    len_cfg = tx_len;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic wait_write(input int max, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk_50M);
            cyc++;
        end while (!bus.tx_write && cyc < max);
        if (!bus.tx_write) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_write: no tx_write within %0d cycles", max);
        end
    endtask

    task automatic wait_idle(input int max);
        int cyc;
        cyc = 0;
        do begin
            @(negedge clk_50M);
            cyc++;
        end while (busy && cyc < max);
        if (busy) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_idle: busy still high after %0d cycles", max);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_tx_write"}, 32'(bus.tx_write), 32'h0);
        check({tag, "_req_ack"},  32'(bus.req_ack),  32'h0);
        check({tag, "_tx_data"},  32'(bus.tx_data),  32'h0);
        check({tag, "_grant_id"}, 32'(grant_id),     32'h0);
        check({tag, "_busy"},     32'(busy),         32'h0);
        check({tag, "_tmo_err"},  32'(timeout_err),  32'h0);
        check({tag, "_tx_count"}, 32'(tx_count),     32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk_50M);
        reset_n = 1'b0;
        bus.req_valid = '0;
        repeat (2) @(negedge clk_50M);
        check_reset("rst");
        reset_n = 1'b1;
    endtask

    // Spec rule: search from last+1 upward, wrapping, first pending requester wins.
    function automatic int rr_ref(input logic [NR-1:0] v, input int last);
        int cand;
        for (int k = 1; k <= NR; k++) begin
            cand = (last + k) % NR;
            if (((int'(v) >> cand) & 1) != 0) return cand;
        end
        return -1;
    endfunction

    typedef struct {
        logic [NR-1:0] valid;
        int            exp_g;
    } vec_t;

    vec_t vt [12];
    logic [7:0] rq [NR][$];

    initial begin
        int cyc;
        int extra;
        int k;
        int ref_last;
        int exp_frames;
        int exp_tmo;
        int seen_tmo;
        bit upd_cfg;
        logic [NR-1:0] prev_valid;
        logic [NR-1:0] v;

        n_cmp = 0;
        n_err = 0;
        stray_busy = 1'b0;
        tx_never = 1'b0;
        tx_delay = 3;
        tx_len = 10;
        bus.req_valid = '0;
        bus.req_data = '0;

        vt[0]  = '{4'b1111, 0};
        vt[1]  = '{4'b1111, 1};
        vt[2]  = '{4'b1111, 2};
        vt[3]  = '{4'b1111, 3};
        vt[4]  = '{4'b1111, 0};
        vt[5]  = '{4'b0100, 2};
        vt[6]  = '{4'b0101, 0};
        vt[7]  = '{4'b0101, 2};
        vt[8]  = '{4'b1000, 3};
        vt[9]  = '{4'b0011, 0};
        vt[10] = '{4'b0010, 1};
        vt[11] = '{4'b1001, 3};

        repeat (3) @(negedge clk_50M);
        check_reset("por");
        reset_n = 1'b1;

        // Single byte from requester 0.
        bus.req_data = 32'h0000_0055;
        bus.req_valid = 4'b0001;
        wait_write(10, cyc);
        check("single_latency", 32'(cyc), 32'd1);
        check("single_grant", 32'(grant_id), 32'd0);
        check("single_ack", 32'(bus.req_ack), 32'h1);
        check("single_data", 32'(bus.tx_data), 32'h55);
        bus.req_valid = '0;
        extra = 0;
        repeat (20) begin
            @(negedge clk_50M);
            if (bus.tx_write) extra++;
        end
        check("single_extra_writes", 32'(extra), 32'd0);
        check("single_count", 32'(tx_count), 32'd1);
        check("single_busy", 32'(busy), 32'd0);

        do_reset();

        // Round-robin vectors from reset (last_grant starts at NR-1).
        bus.req_data = 32'hA3A2_A1A0;
        for (int i = 0; i < 12; i++) begin
            bus.req_valid = vt[i].valid;
            wait_write(8, cyc);
            check($sformatf("vec%0d_latency", i), 32'(cyc), 32'd1);
            check($sformatf("vec%0d_grant", i), 32'(grant_id), 32'(vt[i].exp_g));
            check($sformatf("vec%0d_ack", i), 32'(bus.req_ack), 32'(1 << vt[i].exp_g));
            check($sformatf("vec%0d_data", i), 32'(bus.tx_data), 32'(160 + vt[i].exp_g));
            bus.req_valid = '0;
            @(negedge clk_50M);
            check($sformatf("vec%0d_ack_pulse", i), 32'(bus.req_ack), 32'h0);
            check($sformatf("vec%0d_wr_pulse", i), 32'(bus.tx_write), 32'h0);
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'h1);
            wait_idle(40);
            check($sformatf("vec%0d_count", i), 32'(tx_count), 32'(i + 1));
        end

        // tx_busy never rises: timeout 16 cycles after the write, then service continues.
        tx_never = 1'b1;
        bus.req_valid = 4'b0001;
        wait_write(8, cyc);
        check("tmo_grant", 32'(grant_id), 32'd0);
        bus.req_valid = '0;
        k = 0;
        do begin
            @(negedge clk_50M);
            k++;
        end while (!timeout_err && k < 40);
        check("tmo_delay", 32'(k), 32'd16);
        check("tmo_busy", 32'(busy), 32'd0);
        check("tmo_count", 32'(tx_count), 32'd12);
        @(negedge clk_50M);
        check("tmo_pulse", 32'(timeout_err), 32'd0);
        tx_never = 1'b0;
        bus.req_valid = 4'b0010;
        wait_write(8, cyc);
        check("post_tmo_latency", 32'(cyc), 32'd1);
        check("post_tmo_grant", 32'(grant_id), 32'd1);
        bus.req_valid = '0;
        wait_idle(40);
        check("post_tmo_count", 32'(tx_count), 32'd13);

        // Stray tx_busy while idle must not hold off a grant.
        stray_busy = 1'b1;
        bus.req_valid = 4'b0100;
        wait_write(8, cyc);
        check("stray_latency", 32'(cyc), 32'd1);
        check("stray_grant", 32'(grant_id), 32'd2);
        bus.req_valid = '0;
        repeat (6) @(negedge clk_50M);
        stray_busy = 1'b0;
        wait_idle(40);
        check("stray_count", 32'(tx_count), 32'd14);

        // Frame counter wrap.
        force dut.tx_count_q = 16'hFFFF;
        @(negedge clk_50M);
        release dut.tx_count_q;
        @(negedge clk_50M);
        check("wrap_preload", 32'(tx_count), 32'hFFFF);
        bus.req_valid = 4'b1000;
        wait_write(8, cyc);
        check("wrap_grant", 32'(grant_id), 32'd3);
        bus.req_valid = '0;
        wait_idle(40);
        check("wrap_count", 32'(tx_count), 32'h0);

        // Reset during WAIT_DONE with requester 0 pending.
        bus.req_valid = 4'b0010;
        wait_write(8, cyc);
        check("mid_grant", 32'(grant_id), 32'd1);
        bus.req_valid = 4'b0001;
        k = 0;
        while (!model_busy && k < 20) begin
            @(negedge clk_50M);
            k++;
        end
        repeat (2) @(negedge clk_50M);
        check("mid_busy_before", 32'(busy), 32'd1);
        #5;
        reset_n = 1'b0;
        #1;
        check_reset("mid");
        @(negedge clk_50M);
        @(negedge clk_50M);
        bus.req_valid = 4'b0011;
        reset_n = 1'b1;
        wait_write(8, cyc);
        check("mid_rel_latency", 32'(cyc), 32'd1);
        check("mid_rel_grant", 32'(grant_id), 32'd0);
        check("mid_rel_ack", 32'(bus.req_ack), 32'h1);
        bus.req_valid = '0;
        wait_idle(40);

        // Randomized traffic against the requester-queue model.
        do_reset();
        ref_last = NR - 1;
        exp_frames = 0;
        exp_tmo = 0;
        seen_tmo = 0;
        upd_cfg = 1'b0;
        prev_valid = '0;
        tx_never = 1'b0;
        tx_delay = 2;
        tx_len = 3;
        for (int i = 0; i < NR; i++) rq[i].delete();
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk_50M);
            if (upd_cfg) begin
                tx_never = ($urandom_range(0, 7) == 0);
                tx_delay = $urandom_range(1, 4);
                tx_len = $urandom_range(1, 6);
                upd_cfg = 1'b0;
            end
            if (bus.tx_write) begin
                int g;
                g = rr_ref(prev_valid, ref_last);
                if (g < 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL rnd_spurious_write: got write with no pending request (valid=%b)", prev_valid);
                end else begin
                    check("rnd_grant", 32'(grant_id), 32'(g));
                    check("rnd_ack", 32'(bus.req_ack), 32'(1 << g));
                    check("rnd_data", 32'(bus.tx_data), 32'(rq[g][0]));
                    void'(rq[g].pop_front());
                    ref_last = g;
                end
                if (tx_never) exp_tmo++;
                else exp_frames++;
                upd_cfg = 1'b1;
            end else begin
                check("rnd_noack", 32'(bus.req_ack), 32'h0);
            end
            if (timeout_err) seen_tmo++;
            if (c < 3000) begin
                for (int i = 0; i < NR; i++) begin
                    if (rq[i].size() == 0) begin
                        if ($urandom_range(0, 5) == 0) rq[i].push_back(8'($urandom));
                    end else if ($urandom_range(0, 99) == 0) begin
                        void'(rq[i].pop_front());
                    end
                end
            end
            for (int i = 0; i < NR; i++) begin
                v[i] = (rq[i].size() != 0);
                bus.req_data[8*i +: 8] = v[i] ? rq[i][0] : 8'h00;
            end
            bus.req_valid = v;
            prev_valid = v;
        end
        tx_never = 1'b0;
        check("rnd_drained", 32'(prev_valid), 32'h0);
        check("rnd_idle", 32'(busy), 32'h0);
        check("rnd_count", 32'(tx_count), 32'(exp_frames));
        check("rnd_timeouts", 32'(seen_tmo), 32'(exp_tmo));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of byte requesters sharing one UART transmitter (legal 2..8).
REQ-002 Parameter BUSY_TIMEOUT, default 16: clk cycles allowed between tx_write and tx_busy rising.
REQ-003 clk_50M  input  1  sole clock, 50 MHz, all logic on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  NUM_REQ  per-requester byte-pending flag; held until matching ack.
REQ-006 req_data  input  8*NUM_REQ  packed bytes, requester i in bits [8i+7:8i]; stable while req_valid[i]=1.
REQ-007 req_ack  output  NUM_REQ  one-cycle pulse: byte of requester i accepted.
REQ-008 tx_write  output  1  one-cycle load strobe to transmitter write-latch.
REQ-009 tx_data  output  8  byte presented with tx_write; held until next grant.
REQ-010 tx_busy  input  1  transmitter frame in progress (start bit through stop bit).
REQ-011 grant_id  output  clog2(NUM_REQ)  index of current/last granted requester.
REQ-012 busy  output  1  high whenever FSM not in IDLE.
REQ-013 timeout_err  output  1  one-cycle pulse on tx_busy timeout.
REQ-014 tx_count  output  16  count of completed frames, wraps 0xFFFF->0x0000.

Function
REQ-015 FSM states SHALL be IDLE, WAIT_BUSY, WAIT_DONE; all outputs registered.
REQ-016 IDLE with any req_valid at edge N: SHALL pick winner g by round-robin, searching from (last_grant+1) mod NUM_REQ upward with wrap.
REQ-017 In cycle N+1 SHALL drive tx_write=1, req_ack[g]=1, tx_data=req_data[g], grant_id=g, state=WAIT_BUSY; last_grant<=g.
REQ-018 tx_write and req_ack SHALL be high exactly one cycle per grant; at most one ack bit high per cycle.
REQ-019 WAIT_BUSY: tx_busy=1 -> WAIT_DONE, timeout counter cleared.
REQ-020 WAIT_BUSY: counter increments each cycle; tx_busy still 0 after BUSY_TIMEOUT cycles -> timeout_err pulse, IDLE, tx_count unchanged.
REQ-021 WAIT_DONE: tx_busy=0 -> IDLE, tx_count+1 (modulo 2^16); no new grant in that same cycle.
REQ-022 Minimum gap: one IDLE cycle between tx_busy falling and next tx_write.
REQ-023 req_valid changes outside IDLE SHALL be ignored; a requester deasserting before ack simply loses eligibility.
REQ-024 No req_valid in IDLE: stay IDLE, all strobes 0, last_grant unchanged.
REQ-025 tx_busy=1 while IDLE (stray) SHALL be ignored; no grant is withheld because of it.

Reset
REQ-026 reset_n low SHALL immediately force: state=IDLE, tx_write=0, req_ack=0, tx_data=0x00, grant_id=0, busy=0, timeout_err=0, tx_count=0, timeout counter=0.
REQ-027 last_grant SHALL reset to NUM_REQ-1 so requester 0 has first priority.
REQ-028 Reset mid-frame SHALL abort sequencing without a further ack; pending requester is re-served after release.

Structure
REQ-029 Shared package uart_pkg SHALL hold FSM state enum, default NUM_REQ, BUSY_TIMEOUT and counter width constants.
REQ-030 Round-robin search SHALL be a separate combinational sub-module rr_select (inputs: valid vector, last_grant; outputs: winner, any).
REQ-031 Top-level integration SHALL connect tx_write/tx_data to the transmitter write and write_value inputs.

Verification
REQ-032 After reset, req_valid=4'b0001, req_data[0]=0x55, model tx_busy 3 cycles after write for 10 cycles -> one tx_write, tx_data=0x55, req_ack=0001, tx_count=1.
REQ-033 req_valid=4'b1111 held, data 0xA0..0xA3 -> grants in order 0,1,2,3,0; each ack one cycle; tx_count increments per frame.
REQ-034 last_grant=2, req_valid=4'b0101 -> next grant 0 (wrap), then 2.
REQ-035 tx_busy never asserted after tx_write -> timeout_err pulse exactly 16 cycles later, busy=0, tx_count unchanged, next request served.
REQ-036 reset_n low during WAIT_DONE -> all outputs at reset values same cycle; after release requester 0 granted first.
REQ-037 tx_count preloaded to 0xFFFF via 65535 frames (or forced) -> next completed frame gives 0x0000.
